// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer that drains an upstream TX FIFO.
// Pops a byte whenever the line is idle and frames it as start, data LSB-first, optional parity, stop.
module uart_tx_fifo_drain #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic                  busy_q, busy_d;
  logic                  tx_done_q, tx_done_d;
  logic                  bit_end;

  // Last clock of the current bit period
  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    fifo_rd_d = 1'b0;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_rd_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
        tx_d     = 1'b0;
        baud_d   = '0;
        state_d  = S_START;
      end
      S_START: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          // Chain straight into the next byte when the FIFO still has data
          baud_d    = '0;
          tx_done_d = 1'b1;
          if (!fifo_empty) begin
            fifo_rd_d = 1'b1;
            state_d   = S_FETCH;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (no parity, even, odd) fed by FIFO models,
// every output checked each cycle against a frame-timing model derived from byte lists.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
  localparam int NI  = 3;

  logic       clk;
  logic       rst;
  logic       fifo_empty [NI];
  logic [7:0] fifo_data  [NI];
  logic       fifo_rd    [NI];
  logic       tx         [NI];
  logic       busy       [NI];
  logic       tx_done    [NI];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scenario per instance: byte list, first pop edge, optional reset-abort edge
  logic [7:0] sc_b     [NI][8];
  int         sc_n     [NI];
  int         sc_e0    [NI];
  int         sc_abort [NI];
  logic       sc_act   [NI];
  int         rdptr    [NI];

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
    .fifo_rd(fifo_rd[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_en(input int i);
    return (i != 0) ? 1 : 0;
  endfunction

  function automatic int frame_len(input int i);
    return (10 + par_en(i)) * CPB;
  endfunction

  // Edge offset (from the first pop) at which the last stop bit ends
  function automatic int end_rel(input int i);
    return (sc_n[i] - 1) * (frame_len(i) + 2) + 2 + frame_len(i);
  endfunction

  // Line level for frame slot j of byte b
  function automatic logic frame_bit(input logic [7:0] b, input int j, input int i);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (par_en(i) == 1 && j == 9) return (^b) ^ (i == 2);
    return 1'b1;
  endfunction

  // Expected {fifo_rd, tx, busy, tx_done} after edge c
  function automatic logic [3:0] exp_out(input int i, input int c);
    int p, rel, endc, k, m, j;
    p = frame_len(i) + 2;
    if (!sc_act[i] || c < sc_e0[i]) return 4'b0100;
    if (sc_abort[i] >= 0 && c >= sc_abort[i]) return 4'b0100;
    rel  = c - sc_e0[i];
    endc = end_rel(i);
    if (rel >= endc) return {1'b0, 1'b1, 1'b0, (rel == endc)};
    k = rel / p;
    m = rel % p;
    if (m < 2) return {(m == 0), 1'b1, 1'b1, (m == 0) && (k > 0)};
    j = (m - 2) / CPB;
    return {1'b0, frame_bit(sc_b[i][k], j, i), 1'b1, 1'b0};
  endfunction

  task automatic check_bit(input string tag, input int i, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cyc=%0d got=%b exp=%b", tag, i, cyc, got, exp);
    end
  endtask

  // One clock: FIFO model reacts to the pop strobe, then all outputs are checked
  task automatic tick();
    logic rd_prev [NI];
    logic [3:0] e;
    for (int i = 0; i < NI; i++) rd_prev[i] = fifo_rd[i];
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (rd_prev[i] === 1'b1) begin
        checks++;
        assert (rdptr[i] < sc_n[i]) else begin
          errors++;
          $error("FAIL pop_empty inst=%0d cyc=%0d got=pop exp=no_pop", i, cyc);
        end
        if (rdptr[i] < sc_n[i]) begin
          fifo_data[i] = sc_b[i][rdptr[i]];
          rdptr[i]++;
        end
      end else begin
        fifo_data[i] = 8'($urandom);
      end
      fifo_empty[i] = (rdptr[i] >= sc_n[i]);
      e = exp_out(i, cyc);
      check_bit("fifo_rd", i, fifo_rd[i], e[3]);
      check_bit("tx",      i, tx[i],      e[2]);
      check_bit("busy",    i, busy[i],    e[1]);
      check_bit("tx_done", i, tx_done[i], e[0]);
    end
  endtask

  task automatic arm(input int i, input int n);
    sc_n[i]       = n;
    rdptr[i]      = 0;
    fifo_empty[i] = (n == 0);
    sc_act[i]     = 1'b1;
    sc_abort[i]   = -1;
    sc_e0[i]      = cyc + 1;
  endtask

  function automatic logic all_done();
    for (int i = 0; i < NI; i++)
      if (sc_act[i] && sc_abort[i] < 0 && cyc < sc_e0[i] + end_rel(i) + 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_all();
    for (int t = 0; t < 5000 && !all_done(); t++) tick();
    checks++;
    assert (all_done()) else begin
      errors++;
      $error("FAIL run_timeout cyc=%0d got=busy exp=done", cyc);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      fifo_empty[i] = 1'b1;
      fifo_data[i]  = 8'h00;
      sc_n[i]       = 0;
      rdptr[i]      = 0;
      sc_e0[i]      = 0;
      sc_abort[i]   = -1;
      sc_act[i]     = 1'b0;
    end

    // Reset held with a non-empty FIFO: no pop, line idle
    sc_b[0][0]    = 8'hA1;
    sc_n[0]       = 1;
    fifo_empty[0] = 1'b0;
    repeat (6) tick();

    // Release: single byte 0xA1 drains
    rst = 1'b1;
    arm(0, 1);
    run_all();

    // Two back-to-back bytes
    sc_b[0][0] = 8'hA2;
    sc_b[0][1] = 8'hA3;
    arm(0, 2);
    run_all();

    // Empty FIFO for a long stretch
    repeat (200) tick();

    // Even and odd parity on 0xA1, concurrently
    sc_b[1][0] = 8'hA1;
    sc_b[2][0] = 8'hA1;
    arm(1, 1);
    arm(2, 1);
    run_all();

    // Randomized bursts, staggered across instances
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) begin
        int n;
        n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++) sc_b[i][k] = 8'($urandom);
        arm(i, n);
        repeat (int'($urandom_range(0, 7))) tick();
      end
      run_all();
    end

    // Reset during the third data bit of 0x55
    sc_b[0][0] = 8'h55;
    arm(0, 1);
    while (cyc < sc_e0[0] + 14) tick();
    rst         = 1'b0;
    sc_abort[0] = cyc + 1;
    tick();
    tick();
    rst = 1'b1;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- UART transmit serializer sitting directly downstream of the 8-entry UART TX FIFO.
- Whenever the FIFO is non-empty and the line is idle, it pops one byte, frames it (start, data LSB-first, optional parity, stop) and drives the serial line at a fixed baud.
- Back-to-back bytes drain automatically until the FIFO reports empty.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; matches FIFO width.
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); minimum legal value 2.
- PARITY_EN, 0, 1 inserts a parity bit between the last data bit and stop.
- PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on clk rising edge.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid on the cycle after fifo_rd is high.
- fifo_rd  out  1  one-cycle pop strobe to the FIFO rd input.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the pop until the end of the stop bit.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (rst=0 at an edge): tx=1, fifo_rd=0, busy=0, tx_done=0, state=IDLE, bit and baud counters=0. Any frame in progress is abandoned and its byte is lost.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. On an edge with fifo_empty=0: fifo_rd<=1, busy<=1, go to FETCH. If fifo_empty=1, fifo_rd stays 0 (never pop an empty FIFO).
- FETCH: one cycle. fifo_rd<=0 at the next edge; go to LOAD.
- LOAD: one cycle. The shift register captures fifo_data at the exiting edge; tx<=0; go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of the data bits, inverted if PARITY_ODD=1; held CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle edge, tx_done<=1 for one cycle, then:
  - fifo_empty=0: fifo_rd<=1, busy stays 1, go to FETCH.
  - otherwise: busy<=0, go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. No fractional baud.
- Latency: fifo_rd rises at edge E0; tx falls at E0+2 clk. Frame length is (DATA_WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles of tx.
- Back-to-back bytes: the line stays high exactly 2 clk (FETCH+LOAD) between a stop bit and the next start bit.
- fifo_empty changes mid-frame are ignored; it is only sampled in IDLE and on the final STOP cycle.
- fifo_data is only sampled on the LOAD exit edge.
- Reset asserted in any state wins over all transitions. tx returns high on that edge, with no glitch low.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8):
- Reset held with fifo_empty=0 -> fifo_rd=0, tx=1, busy=0 throughout. Release -> fifo_rd pulses exactly 1 cycle.
- FIFO holds 0xA1, PARITY_EN=0 -> single fifo_rd pulse. tx sampled mid-bit reads 0,1,0,0,0,0,1,0,1,1, each bit 4 clk. tx_done pulses once 40 clk after tx falls. busy drops the same edge.
- FIFO holds 0xA2,0xA3 -> two frames, bits 0,0,1,0,0,0,1,0,1,1 then 0,1,1,0,0,0,1,0,1,1. Exactly 2 clk of high between the first stop end and the second start. Exactly 2 fifo_rd pulses.
- fifo_empty=1 for 200 clk -> fifo_rd never asserted, tx=1, busy=0.
- PARITY_EN=1, PARITY_ODD=0, byte 0xA1 (three ones) -> parity bit 1, frame 44 clk. PARITY_ODD=1 -> parity bit 0.
- rst=0 during the 3rd data bit of 0x55 -> next edge tx=1, busy=0. After release with the FIFO empty, no further fifo_rd or tx_done.
